edge_event_monitor: RTL and testbench

//  Multi-channel edge-event monitor: detects assertion and/or de-assertion of
//  NUM_CH independent 1-bit signals, with per-channel mode select, optional

---
 rtl/edge_mon_pkg.sv | 22 ++
 rtl/edge_mon_chan.sv | 97 +++++++++
 rtl/edge_event_monitor.sv | 44 ++++
 tb/tb_edge_event_monitor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_mon_pkg.sv
// Shared types and helpers for the multi-channel edge-event monitor.
package edge_mon_pkg;

    typedef enum logic [1:0] {
        EM_OFF  = 2'd0,
        EM_RISE = 2'd1,
        EM_FALL = 2'd2,
        EM_BOTH = 2'd3
    } edge_mode_e;

    localparam int MAX_SYNC = 3;

    function automatic logic qualify(edge_mode_e mode, logic rise, logic fall);
        unique case (mode)
            EM_RISE: return rise;
            EM_FALL: return fall;
            EM_BOTH: return rise | fall;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/edge_mon_chan.sv
// One monitored channel: synchroniser, edge compare, event pulse, sticky flag
// and saturating event counter.
module edge_mon_chan
    import edge_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  edge_mode_e       mode,
    input  logic             clr,
    output logic             edge_pulse,
    output logic             sticky,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             cnt_sat
);

    localparam int STAGES = (SYNC_STAGES > MAX_SYNC) ? MAX_SYNC : SYNC_STAGES;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s;
    logic p;
    logic armed;
    logic [STAGES:0] arm_q;

    if (STAGES == 0) begin : g_bypass
        assign s = sig_in;
    end else begin : g_sync
        logic [STAGES-1:0] sync_q;
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of its neighbour.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= sig_in;
                for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end
        assign s = sync_q[STAGES-1];
    end

    // Arming waits until the reset zeros have drained out of the synchroniser,
    // so a level already present at reset release is never seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q <= '0;
            p     <= 1'b0;
        end else begin
            arm_q[0] <= 1'b1;
            for (int i = 1; i <= STAGES; i++) arm_q[i] <= arm_q[i-1];
            p <= s;
        end
    end
    assign armed = arm_q[STAGES];

    logic             qual;
    logic             hit;
    logic             sticky_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        qual       = qualify(mode, armed & s & ~p, armed & ~s & p);
        hit        = qual & en;
        sticky_nxt = sticky;
        cnt_nxt    = evt_cnt;
        if (clr) begin
            sticky_nxt = 1'b0;
            cnt_nxt    = '0;
        end
        if (hit) begin
            sticky_nxt = 1'b1;
            if (clr)                  cnt_nxt = CNT_W'(1);
            else if (evt_cnt != CNT_MAX) cnt_nxt = evt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_pulse <= 1'b0;
            sticky     <= 1'b0;
            evt_cnt    <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            edge_pulse <= qual;
            sticky     <= sticky_nxt;
            evt_cnt    <= cnt_nxt;
            cnt_sat    <= (cnt_nxt == CNT_MAX);
        end
    end

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel edge-event monitor: NUM_CH independent channels plus an
// aggregate interrupt formed from the registered sticky flags.
module edge_event_monitor
    import edge_mon_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       edge_pulse,
    output logic [NUM_CH-1:0]       sticky,
    output logic [CNT_W*NUM_CH-1:0] evt_cnt,
    output logic [NUM_CH-1:0]       cnt_sat,
    output logic                    irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        edge_mon_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .sig_in    (sig_in[i]),
            .mode      (edge_mode_e'(mode[2*i+:2])),
            .clr       (clr[i]),
            .edge_pulse(edge_pulse[i]),
            .sticky    (sticky[i]),
            .evt_cnt   (evt_cnt[CNT_W*i+:CNT_W]),
            .cnt_sat   (cnt_sat[i])
        );
    end

    // Sticky bits are flop outputs, so the OR cannot glitch on input activity.
    assign irq = |sticky;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Directed bench: a 2-stage-synchroniser monitor and a bypass build share the
// same stimulus; checks are immediate assertions plus two SVA properties.
module tb_edge_event_monitor;
    import edge_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [3:0]  sig_in = '0;
    logic [7:0]  mode   = '0;
    logic [3:0]  clr    = '0;

    logic [3:0]  pulse,  sticky,  sat;
    logic [31:0] cnt;
    logic        irq;
    logic [3:0]  p0_pulse, p0_sticky, p0_sat;
    logic [31:0] p0_cnt;
    logic        p0_irq;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    edge_event_monitor #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .mode(mode), .clr(clr),
        .edge_pulse(pulse), .sticky(sticky), .evt_cnt(cnt), .cnt_sat(sat), .irq(irq)
    );

    edge_event_monitor #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .mode(mode), .clr(clr),
        .edge_pulse(p0_pulse), .sticky(p0_sticky), .evt_cnt(p0_cnt), .cnt_sat(p0_sat),
        .irq(p0_irq)
    );

    logic [1:0] arm_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)                arm_cnt <= 2'd0;
        else if (arm_cnt != 3)  arm_cnt <= arm_cnt + 2'd1;
    end

    a_fall_pulse: assert property (@(posedge clk) disable iff (rst)
        (arm_cnt == 2'd3 && $fell(sig_in[0]) && mode[1:0] == EM_FALL) |=> p0_pulse[0])
    else begin
        n_total++;
        $error("FAIL sva_fall_pulse: observed pulse 0 expected 1");
    end

    a_one_cycle: assert property (@(posedge clk) disable iff (rst)
        p0_pulse[0] |=> (!p0_pulse[0] || $changed(sig_in[0])))
    else begin
        n_total++;
        $error("FAIL sva_one_cycle: observed pulse 1 expected 0");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] level);
        rst    = 1'b1;
        sig_in = level;
        clr    = '0;
        tick(2);
        rst    = 1'b0;
    endtask

    logic [3:0] acc_pulse;
    int         sat_bad;
    int         gap;

    initial begin
        // Reset state
        tick(2);
        check("rst_pulse",  {28'd0, pulse},  32'h0);
        check("rst_sticky", {28'd0, sticky}, 32'h0);
        check("rst_cnt",    cnt,             32'h0);
        check("rst_sat",    {28'd0, sat},    32'h0);
        check("rst_irq",    {31'd0, irq},    32'h0);
        rst = 1'b0;

        // 1 / 6: falling edge on ch0, both builds
        mode = {EM_OFF, EM_OFF, EM_OFF, EM_FALL};
        en   = 1'b1;
        sig_in[0] = 1'b1;
        tick(6);
        check("t1_rise_ignored", {28'd0, sticky}, 32'h0);
        sig_in[0] = 1'b0;
        tick(1);
        check("t6_bypass_pulse", {28'd0, p0_pulse}, 32'h1);
        check("t1_pulse_early1", {28'd0, pulse},    32'h0);
        tick(1);
        check("t6_bypass_drop",  {28'd0, p0_pulse}, 32'h0);
        check("t1_pulse_early2", {28'd0, pulse},    32'h0);
        tick(1);
        check("t1_pulse",        {28'd0, pulse},    32'h1);
        check("t1_sticky",       {28'd0, sticky},   32'h1);
        check("t1_cnt",          cnt,               32'h1);
        check("t1_irq",          {31'd0, irq},      32'h1);
        tick(1);
        check("t1_pulse_drop",   {28'd0, pulse},    32'h0);
        sig_in[0] = 1'b1;
        acc_pulse = '0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            acc_pulse |= pulse;
        end
        check("t1_no_rise_pulse", {28'd0, acc_pulse}, 32'h0);
        check("t1_cnt_hold",      cnt,                32'h1);
        clr = 4'b0001;
        tick(1);
        clr = '0;
        check("t1_clr_sticky", {28'd0, sticky}, 32'h0);
        check("t1_clr_irq",    {31'd0, irq},    32'h0);

        // 2: level held high through reset release must not fire
        mode = 8'hFF;
        do_reset(4'hF);
        acc_pulse = '0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            acc_pulse |= pulse | p0_pulse;
        end
        check("t2_no_false_pulse", {28'd0, acc_pulse}, 32'h0);
        check("t2_no_false_cnt",   cnt | p0_cnt,       32'h0);
        sig_in[2] = 1'b0;
        tick(3);
        check("t2_ch2_pulse", {28'd0, pulse}, 32'h4);
        check("t2_ch2_cnt",   cnt,            32'h0001_0000);
        tick(1);
        check("t2_ch2_drop",  {28'd0, pulse}, 32'h0);

        // 3: ch1 toggles every cycle, counter saturates at 255
        mode = {EM_OFF, EM_OFF, EM_BOTH, EM_OFF};
        do_reset(4'h0);
        tick(5);
        sat_bad = 0;
        gap     = 0;
        for (int i = 0; i < 300; i++) begin
            sig_in[1] = ~sig_in[1];
            tick(1);
            if (sat[1] !== (cnt[15:8] == 8'hFF)) sat_bad++;
            if (i >= 2 && pulse[1] !== 1'b1) gap++;
        end
        check("t3_sat_tracks_max", sat_bad,             32'd0);
        check("t3_pulse_held",     gap,                 32'd0);
        check("t3_cnt_saturated",  {24'd0, cnt[15:8]},  32'd255);
        check("t3_sat_flag",       {31'd0, sat[1]},     32'h1);
        tick(4);
        check("t3_no_wrap",        {24'd0, cnt[15:8]},  32'd255);
        clr = 4'b0010;
        tick(1);
        clr = '0;
        check("t3_clr_cnt",    {24'd0, cnt[15:8]}, 32'd0);
        check("t3_clr_sat",    {31'd0, sat[1]},    32'h0);
        check("t3_clr_sticky", {31'd0, sticky[1]}, 32'h0);

        // 4: clear coincident with an event, then event with en low
        mode = {EM_RISE, EM_OFF, EM_OFF, EM_OFF};
        do_reset(4'h0);
        tick(5);
        sig_in[3] = 1'b1;
        tick(4);
        check("t4_first_cnt", {24'd0, cnt[31:24]}, 32'd1);
        sig_in[3] = 1'b0;
        tick(4);
        sig_in[3] = 1'b1;
        tick(2);
        clr = 4'b1000;
        tick(1);
        clr = '0;
        check("t4_clr_evt_pulse",  {31'd0, pulse[3]},  32'h1);
        check("t4_clr_evt_sticky", {31'd0, sticky[3]}, 32'h1);
        check("t4_clr_evt_cnt",    {24'd0, cnt[31:24]}, 32'd1);
        check("t4_clr_evt_sat",    {31'd0, sat[3]},    32'h0);
        sig_in[3] = 1'b0;
        tick(5);
        en = 1'b0;
        sig_in[3] = 1'b1;
        tick(3);
        check("t4_en0_pulse", {31'd0, pulse[3]},   32'h1);
        tick(2);
        check("t4_en0_cnt",   {24'd0, cnt[31:24]}, 32'd1);
        en = 1'b1;

        // 5: asynchronous reset mid-burst
        mode = 8'hFF;
        do_reset(4'h0);
        tick(5);
        for (int i = 0; i < 6; i++) begin
            sig_in = ~sig_in;
            tick(1);
        end
        check("t5_pre_cnt_nz", {31'd0, cnt != 32'h0}, 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_pulse",  {28'd0, pulse | p0_pulse},   32'h0);
        check("t5_async_sticky", {28'd0, sticky | p0_sticky}, 32'h0);
        check("t5_async_cnt",    cnt | p0_cnt,                32'h0);
        check("t5_async_sat",    {28'd0, sat | p0_sat},       32'h0);
        check("t5_async_irq",    {31'd0, irq | p0_irq},       32'h0);
        sig_in = 4'hF;
        tick(2);
        rst = 1'b0;
        acc_pulse = '0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            acc_pulse |= pulse | p0_pulse;
        end
        check("t5_no_false_pulse", {28'd0, acc_pulse}, 32'h0);
        check("t5_no_false_cnt",   cnt | p0_cnt,       32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
